// File: rtl/gray_updown_counter.sv
// Up/down counter that publishes its state as registered binary and registered Gray code.
// Wraps or saturates at the limits, and accepts parallel loads in either binary or Gray form.
module gray_updown_counter #(
  parameter int unsigned            VEC_W   = 4,
  parameter bit                     WRAP_EN = 1'b1,
  parameter logic [VEC_W-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic             load_gray_i,
  input  logic [VEC_W-1:0] load_val_i,
  output logic [VEC_W-1:0] bin_o,
  output logic [VEC_W-1:0] gray_o,
  output logic             ovf_o,
  output logic             at_max_o,
  output logic             at_min_o
);

  localparam logic [VEC_W-1:0] MAX_VAL  = '1;
  localparam logic [VEC_W-1:0] ZERO_VAL = '0;
  localparam logic [VEC_W-1:0] ONE_VAL  = {{(VEC_W-1){1'b0}}, 1'b1};
  localparam logic [VEC_W-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

  logic [VEC_W-1:0] bin_q, bin_d;
  logic [VEC_W-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;

  // Prefix XOR from the MSB down turns a Gray word back into binary.
  function automatic logic [VEC_W-1:0] gray2bin(input logic [VEC_W-1:0] g);
    logic [VEC_W-1:0] b;
    b = '0;
    b[VEC_W-1] = g[VEC_W-1];
    for (int i = VEC_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    bin_d = bin_q;
    ovf_d = 1'b0;
    if (load_i) begin
      bin_d = load_gray_i ? gray2bin(load_val_i) : load_val_i;
    end else if (en_i) begin
      if (dir_i) begin
        if (bin_q == MAX_VAL) begin
          ovf_d = 1'b1;
          bin_d = WRAP_EN ? ZERO_VAL : MAX_VAL;
        end else begin
          bin_d = bin_q + ONE_VAL;
        end
      end else begin
        if (bin_q == ZERO_VAL) begin
          ovf_d = 1'b1;
          bin_d = WRAP_EN ? MAX_VAL : ZERO_VAL;
        end else begin
          bin_d = bin_q - ONE_VAL;
        end
      end
    end
    // Gray is registered from the next binary value so the output never glitches.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= RST_VAL;
      gray_q <= RST_GRAY;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bin_o    = bin_q;
  assign gray_o   = gray_q;
  assign ovf_o    = ovf_q;
  assign at_max_o = (bin_q == MAX_VAL);
  assign at_min_o = (bin_q == ZERO_VAL);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench: three counter instances (7-bit wrap, 4-bit wrap, 4-bit saturate) share one
// stimulus stream; an arithmetic reference model predicts each instance's outputs per cycle.
module tb_gray_updown_counter;

  logic clk;
  logic reset, en_i, dir_i, load_i, load_gray_i;
  logic [6:0] load_val_i;

  logic [6:0] b7, g7;
  logic [3:0] bw, gw, bs, gs;
  logic o7, ow, os, mx7, mxw, mxs, mn7, mnw, mns;

  gray_updown_counter #(.VEC_W(7), .WRAP_EN(1'b1), .RST_VAL(7'd3)) u_w7 (
    .clk(clk), .reset(reset), .en_i(en_i), .dir_i(dir_i), .load_i(load_i),
    .load_gray_i(load_gray_i), .load_val_i(load_val_i), .bin_o(b7), .gray_o(g7),
    .ovf_o(o7), .at_max_o(mx7), .at_min_o(mn7));

  gray_updown_counter #(.VEC_W(4), .WRAP_EN(1'b1), .RST_VAL(4'd5)) u_w4 (
    .clk(clk), .reset(reset), .en_i(en_i), .dir_i(dir_i), .load_i(load_i),
    .load_gray_i(load_gray_i), .load_val_i(load_val_i[3:0]), .bin_o(bw), .gray_o(gw),
    .ovf_o(ow), .at_max_o(mxw), .at_min_o(mnw));

  gray_updown_counter #(.VEC_W(4), .WRAP_EN(1'b0), .RST_VAL(4'd5)) u_s4 (
    .clk(clk), .reset(reset), .en_i(en_i), .dir_i(dir_i), .load_i(load_i),
    .load_gray_i(load_gray_i), .load_val_i(load_val_i[3:0]), .bin_o(bs), .gray_o(gs),
    .ovf_o(os), .at_max_o(mxs), .at_min_o(mns));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0][31:0] bin;
    logic [2:0]       ovf;
    logic [2:0]       flip;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_bin [3];
  int   prev_g [3];

  function automatic int wid(input int k);
    return (k == 0) ? 7 : 4;
  endfunction

  function automatic bit wraps(input int k);
    return (k != 2);
  endfunction

  function automatic int rstv(input int k);
    return (k == 0) ? 3 : 5;
  endfunction

  // Gray decode by exhaustive search for the binary value whose Gray image matches.
  function automatic int g2b(input int g, input int w);
    for (int b = 0; b < (1 << w); b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic int act_bin(input int k);
    case (k)
      0:       return int'(b7);
      1:       return int'(bw);
      default: return int'(bs);
    endcase
  endfunction

  function automatic int act_gray(input int k);
    case (k)
      0:       return int'(g7);
      1:       return int'(gw);
      default: return int'(gs);
    endcase
  endfunction

  function automatic int act_ovf(input int k);
    case (k)
      0:       return int'(o7);
      1:       return int'(ow);
      default: return int'(os);
    endcase
  endfunction

  function automatic int act_max(input int k);
    case (k)
      0:       return int'(mx7);
      1:       return int'(mxw);
      default: return int'(mxs);
    endcase
  endfunction

  function automatic int act_min(input int k);
    case (k)
      0:       return int'(mn7);
      1:       return int'(mnw);
      default: return int'(mns);
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d actual=%0d expected=%0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and push what every instance must show after the next edge.
  task automatic cyc(input bit rst, input bit ld, input bit lg, input int lv,
                     input bit en, input bit dir);
    exp_t e;
    int   mx, v, cur, nb;
    bit   ov;
    @(negedge clk);
    reset = rst; load_i = ld; load_gray_i = lg; load_val_i = 7'(lv);
    en_i = en; dir_i = dir;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      mx  = (1 << wid(k)) - 1;
      v   = lv & mx;
      cur = m_bin[k];
      nb  = cur;
      ov  = 1'b0;
      if (rst)      nb = rstv(k);
      else if (ld)  nb = lg ? g2b(v, wid(k)) : v;
      else if (en) begin
        if (dir) begin
          if (cur == mx) begin ov = 1'b1; nb = wraps(k) ? 0 : mx; end
          else nb = cur + 1;
        end else begin
          if (cur == 0) begin ov = 1'b1; nb = wraps(k) ? mx : 0; end
          else nb = cur - 1;
        end
      end
      e.bin[k]  = 32'(nb);
      e.ovf[k]  = ov;
      e.flip[k] = !rst && !ld && en && (nb != cur);
      m_bin[k]  = nb;
    end
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic dchk(input int k, input int eb, input int eg, input int eo);
    chk("direct_bin", k, act_bin(k), eb);
    chk("direct_gray", k, act_gray(k), eg);
    chk("direct_ovf", k, act_ovf(k), eo);
  endtask

  // Monitor: every edge with a pending expectation is compared against all three instances.
  initial begin
    exp_t e;
    int   eb;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
          eb = int'(e.bin[k]);
          chk("bin", k, act_bin(k), eb);
          chk("gray", k, act_gray(k), eb ^ (eb >> 1));
          chk("ovf", k, act_ovf(k), int'(e.ovf[k]));
          chk("at_max", k, act_max(k), int'(eb == (1 << wid(k)) - 1));
          chk("at_min", k, act_min(k), int'(eb == 0));
          if (e.flip[k]) chk("gray_one_bit", k, $countones(act_gray(k) ^ prev_g[k]), 1);
          prev_g[k] = act_gray(k);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; en_i = 1'b0; dir_i = 1'b0; load_i = 1'b0; load_gray_i = 1'b0;
    load_val_i = '0;
    for (int k = 0; k < 3; k++) begin m_bin[k] = 0; prev_g[k] = 0; end

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1);
    settle();
    dchk(1, 5, 4'b0111, 0);
    dchk(2, 5, 4'b0111, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 1, 0, 9, 1, 1);
    settle();
    dchk(1, 5, 4'b0111, 0);

    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 0, 0, 1, 1);
      if (i == 15) begin settle(); dchk(1, 15, 4'b1000, 0); end
      if (i == 16) begin settle(); dchk(1, 0, 0, 1); dchk(2, 15, 4'b1000, 1); end
    end

    cyc(0, 0, 0, 0, 1, 0);
    settle();
    dchk(1, 15, 4'b1000, 1);
    cyc(0, 0, 0, 0, 0, 0);
    settle();
    dchk(1, 15, 4'b1000, 0);

    cyc(0, 1, 0, 14, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, 1);
      settle();
      dchk(2, 15, 4'b1000, (i > 0) ? 1 : 0);
      chk("direct_at_max", 2, int'(mxs), 1);
    end
    cyc(0, 0, 0, 0, 1, 0);
    settle();
    dchk(2, 14, 4'b1001, 0);

    cyc(0, 1, 1, 4'b1101, 0, 0);
    settle();
    dchk(1, 9, 4'b1101, 0);
    cyc(0, 1, 0, 15, 0, 0);
    cyc(0, 1, 0, 15, 1, 1);
    settle();
    dchk(1, 15, 4'b1000, 0);
    dchk(2, 15, 4'b1000, 0);

    for (int n = 0; n < 10000; n++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(7) == 0), 1'($urandom),
          int'($urandom_range(127)), ($urandom_range(3) != 0), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 0, sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
